n1_dsp_arb: RTL and testbench

//  Arbiter and sequencer that shares one pipelined DSP adder/subtractor between
//  two requesters: flow control (PC target calculation) and ALU (add/sub).

---
 rtl/n1_dsp_pkg.sv | 14 +
 rtl/n1_dsp_arb_pipe.sv | 58 +++++
 rtl/n1_dsp_arb.sv | 123 ++++++++++++
 tb/tb_n1_dsp_arb.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/n1_dsp_pkg.sv
// Shared types for the N1 DSP adder arbiter: requester id, in-flight tag, adder width.
package n1_dsp_pkg;

  localparam int N1_DSP_ADD_W = 16;

  typedef enum logic {REQ_FC, REQ_ALU} dsp_req_t;

  typedef struct packed {
    logic     valid;
    dsp_req_t id;
    logic     sub;
  } dsp_tag_t;

endpackage

// File: rtl/n1_dsp_arb_pipe.sv
// LAT-deep delay line carrying the tag and raw 17-bit adder output of each issued op.
// Never stalls; both resets clear every stage so in-flight ops vanish.
module n1_dsp_arb_pipe
  import n1_dsp_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic                  clk_i,
  input  logic                  async_rst_i,
  input  logic                  sync_rst_i,
  input  logic                  vld_i,
  input  logic                  id_i,
  input  logic                  sub_i,
  input  logic [N1_DSP_ADD_W:0] sum_i,
  output logic                  vld_o,
  output logic                  id_o,
  output logic                  sub_o,
  output logic [N1_DSP_ADD_W:0] sum_o,
  output logic                  busy_o
);

  dsp_tag_t              tag_q [LAT];
  logic [N1_DSP_ADD_W:0] sum_q [LAT];

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= '0;
        sum_q[i] <= '0;
      end
    end else if (sync_rst_i) begin
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= '0;
        sum_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= '{valid: vld_i, id: dsp_req_t'(id_i), sub: sub_i};
      sum_q[0] <= sum_i;
      for (int i = 1; i < LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
        sum_q[i] <= sum_q[i-1];
      end
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      busy_o = busy_o | tag_q[i].valid;
    end
  end

  assign vld_o = tag_q[LAT-1].valid;
  assign id_o  = tag_q[LAT-1].id;
  assign sub_o = tag_q[LAT-1].sub;
  assign sum_o = sum_q[LAT-1];

endmodule

// File: rtl/n1_dsp_arb.sv
// Shares one pipelined add/sub between flow control (FC) and ALU with starvation guard.
// Grant is combinational; results return LAT cycles after ack, in issue order.
module n1_dsp_arb
  import n1_dsp_pkg::*;
#(
  parameter int LAT        = 1,
  parameter int STARVE_LIM = 3
) (
  input  logic        clk_i,
  input  logic        async_rst_i,
  input  logic        sync_rst_i,
  input  logic        fc_req_i,
  input  logic [15:0] fc_op0_i,
  input  logic [15:0] fc_op1_i,
  output logic        fc_ack_o,
  output logic        fc_rdy_o,
  output logic [15:0] fc_res_o,
  input  logic        alu_req_i,
  input  logic        alu_sub_add_b_i,
  input  logic [15:0] alu_op0_i,
  input  logic [15:0] alu_op1_i,
  output logic        alu_ack_o,
  output logic        alu_rdy_o,
  output logic [16:0] alu_res_o,
  output logic        busy_o
);

  localparam int SW = (STARVE_LIM < 2) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

  logic [SW-1:0]             starve_q, starve_d;
  logic [N1_DSP_ADD_W-1:0]   fc_res_q, fc_res_d;
  logic [N1_DSP_ADD_W:0]     alu_res_q, alu_res_d;

  logic                      rst_any;
  logic                      alu_force;
  logic                      fc_gnt;
  logic                      alu_gnt;
  logic [N1_DSP_ADD_W-1:0]   add_a;
  logic [N1_DSP_ADD_W-1:0]   add_b;
  logic                      add_sub;
  logic [N1_DSP_ADD_W:0]     add_sum;

  logic                      p_vld;
  logic                      p_id;
  logic                      p_sub;
  logic [N1_DSP_ADD_W:0]     p_sum;
  logic [N1_DSP_ADD_W:0]     p_alu_res;

  assign rst_any = async_rst_i | sync_rst_i;

  // A reset cycle issues nothing, so no ack is ever given for an op that gets dropped.
  always_comb begin
    alu_force = alu_req_i && (starve_q == STARVE_MAX);
    fc_gnt    = fc_req_i && !alu_force && !rst_any;
    alu_gnt   = alu_req_i && !fc_gnt && !rst_any;

    starve_d = '0;
    if (alu_req_i && !alu_gnt) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
    end
  end

  always_comb begin
    add_a   = fc_op1_i;
    add_b   = fc_op0_i;
    add_sub = 1'b0;
    if (alu_gnt) begin
      add_a   = alu_op1_i;
      add_b   = alu_op0_i;
      add_sub = alu_sub_add_b_i;
    end
    add_sum = {1'b0, add_a} + {1'b0, add_sub ? ~add_b : add_b}
            + {{N1_DSP_ADD_W{1'b0}}, add_sub};
  end

  n1_dsp_arb_pipe #(.LAT(LAT)) u_pipe (
    .clk_i       (clk_i),
    .async_rst_i (async_rst_i),
    .sync_rst_i  (sync_rst_i),
    .vld_i       (fc_gnt | alu_gnt),
    .id_i        (alu_gnt),
    .sub_i       (add_sub),
    .sum_i       (add_sum),
    .vld_o       (p_vld),
    .id_o        (p_id),
    .sub_o       (p_sub),
    .sum_o       (p_sum),
    .busy_o      (busy_o)
  );

  // Carry out of the ~op0+1 form is the inverse of borrow.
  assign p_alu_res = {p_sum[N1_DSP_ADD_W] ^ p_sub, p_sum[N1_DSP_ADD_W-1:0]};

  always_comb begin
    fc_rdy_o  = p_vld && (dsp_req_t'(p_id) == REQ_FC)  && !sync_rst_i;
    alu_rdy_o = p_vld && (dsp_req_t'(p_id) == REQ_ALU) && !sync_rst_i;
    fc_res_d  = fc_rdy_o  ? p_sum[N1_DSP_ADD_W-1:0] : fc_res_q;
    alu_res_d = alu_rdy_o ? p_alu_res : alu_res_q;
  end

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      starve_q  <= '0;
      fc_res_q  <= '0;
      alu_res_q <= '0;
    end else if (sync_rst_i) begin
      starve_q  <= '0;
      fc_res_q  <= '0;
      alu_res_q <= '0;
    end else begin
      starve_q  <= starve_d;
      fc_res_q  <= fc_res_d;
      alu_res_q <= alu_res_d;
    end
  end

  assign fc_ack_o  = fc_gnt;
  assign alu_ack_o = alu_gnt;
  assign fc_res_o  = fc_res_d;
  assign alu_res_o = alu_res_d;

endmodule

// File: tb/tb_n1_dsp_arb.sv
// Bench for n1_dsp_arb (LAT=3, STARVE_LIM=3): vector table, scoreboard monitor, corner sequences.
module tb_n1_dsp_arb;

  localparam int LAT  = 3;
  localparam int SLIM = 3;

  logic        clk_i = 1'b0;
  logic        async_rst_i = 1'b0;
  logic        sync_rst_i = 1'b0;
  logic        fc_req_i = 1'b0;
  logic [15:0] fc_op0_i = '0;
  logic [15:0] fc_op1_i = '0;
  logic        fc_ack_o;
  logic        fc_rdy_o;
  logic [15:0] fc_res_o;
  logic        alu_req_i = 1'b0;
  logic        alu_sub_add_b_i = 1'b0;
  logic [15:0] alu_op0_i = '0;
  logic [15:0] alu_op1_i = '0;
  logic        alu_ack_o;
  logic        alu_rdy_o;
  logic [16:0] alu_res_o;
  logic        busy_o;

  n1_dsp_arb #(.LAT(LAT), .STARVE_LIM(SLIM)) dut (
    .clk_i           (clk_i),
    .async_rst_i     (async_rst_i),
    .sync_rst_i      (sync_rst_i),
    .fc_req_i        (fc_req_i),
    .fc_op0_i        (fc_op0_i),
    .fc_op1_i        (fc_op1_i),
    .fc_ack_o        (fc_ack_o),
    .fc_rdy_o        (fc_rdy_o),
    .fc_res_o        (fc_res_o),
    .alu_req_i       (alu_req_i),
    .alu_sub_add_b_i (alu_sub_add_b_i),
    .alu_op0_i       (alu_op0_i),
    .alu_op1_i       (alu_op1_i),
    .alu_ack_o       (alu_ack_o),
    .alu_rdy_o       (alu_rdy_o),
    .alu_res_o       (alu_res_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] f_alu(input logic sub, input logic [15:0] a0, input logic [15:0] a1);
    if (sub) return {1'b0, a1} - {1'b0, a0};
    return {1'b0, a1} + {1'b0, a0};
  endfunction

  // Scoreboard: expected result and due cycle pushed on ack, popped on rdy.
  typedef struct {
    int          cyc;
    logic [16:0] res;
  } sb_t;

  sb_t         fcq[$];
  sb_t         aluq[$];
  int          cyc = 0;
  int          m_starve = 0;
  logic [15:0] m_fc_hold = '0;
  logic [16:0] m_alu_hold = '0;

  always @(negedge clk_i) begin
    logic e_fc, e_alu, force_alu, e_fr, e_ar;
    cyc++;
    if (async_rst_i) begin
      chk("arst_fc_ack", fc_ack_o, 0);
      chk("arst_alu_ack", alu_ack_o, 0);
      chk("arst_fc_rdy", fc_rdy_o, 0);
      chk("arst_alu_rdy", alu_rdy_o, 0);
      chk("arst_fc_res", fc_res_o, 0);
      chk("arst_alu_res", alu_res_o, 0);
      chk("arst_busy", busy_o, 0);
      fcq.delete(); aluq.delete();
      m_starve = 0; m_fc_hold = '0; m_alu_hold = '0;
    end else if (sync_rst_i) begin
      chk("srst_fc_ack", fc_ack_o, 0);
      chk("srst_alu_ack", alu_ack_o, 0);
      chk("srst_fc_rdy", fc_rdy_o, 0);
      chk("srst_alu_rdy", alu_rdy_o, 0);
      fcq.delete(); aluq.delete();
      m_starve = 0; m_fc_hold = '0; m_alu_hold = '0;
    end else begin
      chk("sb_busy", busy_o, 32'((fcq.size() + aluq.size()) != 0));
      force_alu = alu_req_i && (m_starve == SLIM);
      e_fc  = fc_req_i && !force_alu;
      e_alu = alu_req_i && !e_fc;
      chk("sb_fc_ack", fc_ack_o, e_fc);
      chk("sb_alu_ack", alu_ack_o, e_alu);

      e_fr = (fcq.size() > 0) && (fcq[0].cyc == cyc);
      chk("sb_fc_rdy", fc_rdy_o, e_fr);
      if (e_fr) begin
        m_fc_hold = fcq[0].res[15:0];
        void'(fcq.pop_front());
      end else if (fcq.size() > 0 && fcq[0].cyc < cyc) begin
        void'(fcq.pop_front());
      end
      chk("sb_fc_res", fc_res_o, m_fc_hold);

      e_ar = (aluq.size() > 0) && (aluq[0].cyc == cyc);
      chk("sb_alu_rdy", alu_rdy_o, e_ar);
      if (e_ar) begin
        m_alu_hold = aluq[0].res;
        void'(aluq.pop_front());
      end else if (aluq.size() > 0 && aluq[0].cyc < cyc) begin
        void'(aluq.pop_front());
      end
      chk("sb_alu_res", alu_res_o, m_alu_hold);

      if (e_fc)  fcq.push_back('{cyc + LAT, {1'b0, fc_op1_i + fc_op0_i}});
      if (e_alu) aluq.push_back('{cyc + LAT, f_alu(alu_sub_add_b_i, alu_op0_i, alu_op1_i)});
      m_starve = (alu_req_i && !e_alu) ? ((m_starve < SLIM) ? m_starve + 1 : SLIM) : 0;
    end
  end

  typedef struct {
    logic        is_alu;
    logic        sub;
    logic [15:0] op0;
    logic [15:0] op1;
    logic [16:0] exp;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int   n;
    logic ack;
    @(posedge clk_i); #1;
    if (v.is_alu) begin
      alu_req_i = 1'b1; alu_sub_add_b_i = v.sub; alu_op0_i = v.op0; alu_op1_i = v.op1;
    end else begin
      fc_req_i = 1'b1; fc_op0_i = v.op0; fc_op1_i = v.op1;
    end
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
      ack = v.is_alu ? alu_ack_o : fc_ack_o;
    end while (!ack && n < 20);
    chk($sformatf("vec%0d_ack", idx), ack, 1);
    @(posedge clk_i); #1;
    fc_req_i = 1'b0; alu_req_i = 1'b0;
    repeat (LAT - 1) @(posedge clk_i);
    @(negedge clk_i);
    if (v.is_alu) begin
      chk($sformatf("vec%0d_alu_rdy", idx), alu_rdy_o, 1);
      chk($sformatf("vec%0d_alu_res", idx), alu_res_o, v.exp);
    end else begin
      chk($sformatf("vec%0d_fc_rdy", idx), fc_rdy_o, 1);
      chk($sformatf("vec%0d_fc_res", idx), {1'b0, fc_res_o}, v.exp);
    end
  endtask

  vec_t        vecs[8];
  logic [15:0] pa[4];
  logic [15:0] pb[4];
  logic [16:0] pe[4];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 16'hFFFE, 16'h1000, 17'h00FFE};
    vecs[1] = '{1'b1, 1'b1, 16'h0007, 16'h0005, 17'h1FFFE};
    vecs[2] = '{1'b1, 1'b1, 16'h0005, 16'h0007, 17'h00002};
    vecs[3] = '{1'b1, 1'b0, 16'h0001, 16'hFFFF, 17'h10000};
    vecs[4] = '{1'b1, 1'b0, 16'h1111, 16'h1234, 17'h02345};
    vecs[5] = '{1'b1, 1'b1, 16'h0000, 16'h0000, 17'h00000};
    vecs[6] = '{1'b0, 1'b0, 16'h0002, 16'hFFFF, 17'h00001};
    vecs[7] = '{1'b1, 1'b0, 16'h8000, 16'h8000, 17'h10000};
    pa = '{16'hFFFF, 16'h0001, 16'h8000, 16'hAAAA};
    pb = '{16'h0001, 16'h0002, 16'h7FFF, 16'h5555};
    pe = '{17'h10000, 17'h00003, 17'h0FFFF, 17'h0FFFF};

    #1 async_rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 async_rst_i = 1'b0;

    for (int k = 0; k < 8; k++) run_vec(vecs[k], k);

    // Contention: FC,FC,FC,ALU repeating.
    @(posedge clk_i); #1;
    fc_req_i = 1'b1; fc_op0_i = 16'h0010; fc_op1_i = 16'h2000;
    alu_req_i = 1'b1; alu_sub_add_b_i = 1'b0; alu_op0_i = 16'h0003; alu_op1_i = 16'h0004;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      chk("cont_fc_ack", fc_ack_o, 32'((i % 4) != 3));
      chk("cont_alu_ack", alu_ack_o, 32'((i % 4) == 3));
    end
    @(posedge clk_i); #1;
    fc_req_i = 1'b0; alu_req_i = 1'b0;
    repeat (LAT + 2) @(posedge clk_i);

    // Four back-to-back ALU adds.
    #1 alu_req_i = 1'b1; alu_sub_add_b_i = 1'b0;
    for (int j = 0; j < 4 + LAT; j++) begin
      if (j < 4) begin
        alu_op1_i = pa[j]; alu_op0_i = pb[j];
      end else begin
        alu_req_i = 1'b0;
      end
      @(negedge clk_i);
      if (j < 4) chk("pipe_ack", alu_ack_o, 1);
      if (j >= LAT) begin
        chk($sformatf("pipe_rdy%0d", j - LAT), alu_rdy_o, 1);
        chk($sformatf("pipe_res%0d", j - LAT), alu_res_o, pe[j - LAT]);
      end else begin
        chk("pipe_no_rdy", alu_rdy_o, 0);
      end
      @(posedge clk_i); #1;
    end
    repeat (2) @(posedge clk_i);

    // Async reset with an FC and an ALU op in flight.
    #1 fc_req_i = 1'b1; fc_op0_i = 16'h0100; fc_op1_i = 16'h0200;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    fc_req_i = 1'b0; alu_req_i = 1'b1; alu_sub_add_b_i = 1'b1; alu_op0_i = 16'h0001; alu_op1_i = 16'h0009;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    alu_req_i = 1'b0;
    #2 async_rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #3 async_rst_i = 1'b0;
    for (int j = 0; j < LAT + 3; j++) begin
      @(negedge clk_i);
      chk("arst_after_fc_rdy", fc_rdy_o, 0);
      chk("arst_after_alu_rdy", alu_rdy_o, 0);
      chk("arst_after_fc_res", fc_res_o, 0);
      chk("arst_after_alu_res", alu_res_o, 0);
      chk("arst_after_busy", busy_o, 0);
    end

    // Sync reset with two FC ops in flight and ALU partially starved.
    @(posedge clk_i); #1;
    fc_req_i = 1'b1; fc_op0_i = 16'h0005; fc_op1_i = 16'h0050;
    alu_req_i = 1'b1; alu_sub_add_b_i = 1'b0; alu_op0_i = 16'h0001; alu_op1_i = 16'h0001;
    repeat (2) begin
      @(negedge clk_i);
      chk("srst_pre_fc_ack", fc_ack_o, 1);
      @(posedge clk_i); #1;
    end
    sync_rst_i = 1'b1;
    @(negedge clk_i);
    chk("srst_cycle_ack", {fc_ack_o, alu_ack_o}, 0);
    @(posedge clk_i); #1;
    sync_rst_i = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk_i);
      chk("srst_post_fc_ack", fc_ack_o, 32'((j % 4) != 3));
      chk("srst_post_alu_ack", alu_ack_o, 32'((j % 4) == 3));
      if (j < 3) chk("srst_dropped_rdy", fc_rdy_o, 0);
    end
    @(posedge clk_i); #1;
    fc_req_i = 1'b0; alu_req_i = 1'b0;
    repeat (LAT + 3) @(posedge clk_i);
    @(negedge clk_i);
    chk("sb_drained", fcq.size() + aluq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
